key_event_decoder: RTL
======================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CNT, default 50_000_000: hold cycles until a long press (1 s at 50 MHz).
REQ-002 SHALL have parameter DCLICK_CNT, default 15_000_000: maximum release-to-press gap for a double click (300 ms).
REQ-003 SHALL have parameter REPEAT_CNT, default 10_000_000: auto-repeat period during a long hold (200 ms).
REQ-004 SHALL have parameter CNT_W, default 26: internal counter width; all CNT parameters SHALL fit CNT_W bits.
REQ-005 sys_clk  input  1  system clock; all logic on the rising edge.
REQ-006 sys_rst_n  input  1  asynchronous active-low reset.
REQ-007 keyflag  input  1  one-cycle strobe: debounced key value updated.
REQ-008 keyvalue  input  1  debounced key level, sampled only when keyflag=1; 0=pressed, 1=released.
REQ-009 click  output  1  one-cycle pulse: single short click completed.
REQ-010 dclick  output  1  one-cycle pulse: double click completed.
REQ-011 lpress  output  1  one-cycle pulse: long-press threshold reached.
REQ-012 repeat  output  1  one-cycle pulse every REPEAT_CNT cycles while long-held.
REQ-013 held  output  1  level; 1 while the decoder considers the key pressed.

Function
REQ-014 Press event = keyflag&keyvalue==0; release event = keyflag&keyvalue==1; keyvalue without keyflag SHALL be ignored.
REQ-015 FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG; one shared counter cnt, cleared on every state change.
REQ-016 IDLE: press -> PRESS1; release ignored.
REQ-017 PRESS1: cnt increments each cycle; release -> WAIT2; cnt==LONG_CNT-1 -> LONG with lpress.
REQ-018 WAIT2: press -> PRESS2; cnt==DCLICK_CNT-1 with no press -> IDLE with click.
REQ-019 PRESS2: release -> IDLE with dclick; cnt==LONG_CNT-1 -> LONG with lpress, no dclick.
REQ-020 LONG: cnt counts 0..REPEAT_CNT-1 and wraps; repeat pulses on each wrap; release -> IDLE, no click/dclick.
REQ-021 Same-cycle event and timeout: the event SHALL win (e.g. press at WAIT2 timeout -> PRESS2, no click).
REQ-022 Redundant events (press while pressed, release while released) SHALL be ignored with no state or cnt change.
REQ-023 All outputs SHALL be registered; a pulse SHALL appear on the cycle after the triggering edge and last exactly one cycle.
REQ-024 At most one of click/dclick/lpress/repeat SHALL be high in any cycle.
REQ-025 held SHALL be 1 in PRESS1, PRESS2, LONG and 0 otherwise, registered in step with the state.
REQ-026 cnt SHALL never exceed its state limit; no wrap-around beyond CNT_W.

Reset
REQ-027 On sys_rst_n=0, asynchronously: state=IDLE, cnt=0, click=dclick=lpress=repeat=held=0.
REQ-028 Reset mid-sequence SHALL abandon the sequence with no pulse; after release the first press SHALL start from IDLE.

Structure
REQ-029 State encoding and default CNT values SHALL live in shared package key_pkg.
REQ-030 Single module, no sub-module; one counter, one FSM register, registered outputs.

Verification (LONG_CNT=8, DCLICK_CNT=5, REPEAT_CNT=3)
REQ-031 Press, release 3 cycles later, no further press -> one click pulse 5 cycles after release; dclick/lpress stay 0.
REQ-032 Press, release, press 2 cycles later, release -> one dclick on the cycle after the second release; no click.
REQ-033 Press held 15 cycles -> lpress 8 cycles after press, then repeat every 3 cycles; release -> held=0, no click.
REQ-034 In WAIT2, press exactly on the cnt==4 cycle -> PRESS2, no click pulse.
REQ-035 Reset asserted in PRESS1 at cnt=5 -> all outputs 0 immediately; no pulse after reset release.
REQ-036 keyvalue toggling with keyflag=0, or a repeated press strobe while pressed -> no state change, no pulses.

Source files
------------

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key event decoder: FSM state encoding,
// default timing constants (50 MHz system clock) and a small helper.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package key_pkg;

  // Default timing constants, in sys_clk cycles at 50 MHz.
  localparam int unsigned LONG_CNT_DEF   = 50_000_000;  // 1 s hold -> long press
  localparam int unsigned DCLICK_CNT_DEF = 15_000_000;  // 300 ms double-click window
  localparam int unsigned REPEAT_CNT_DEF = 10_000_000;  // 200 ms auto-repeat period
  localparam int unsigned CNT_W_DEF      = 26;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } key_state_e;

  // The key is considered pressed in every state that waits for a release.
  function automatic logic state_is_held(input key_state_e s);
    return (s == ST_PRESS1) || (s == ST_PRESS2) || (s == ST_LONG);
  endfunction

endpackage : key_pkg

`default_nettype wire

// File: rtl/key_event_decoder.sv
// ---------------------------------------------------------------------------
// key_event_decoder
// Turns debounced key press/release strobes into single-click, double-click,
// long-press and auto-repeat pulses, plus a held level.
//
// Ports
//   sys_clk   in   system clock, rising edge
//   sys_rst_n in   asynchronous active-low reset
//   keyflag   in   one-cycle strobe: keyvalue has been updated
//   keyvalue  in   debounced key level (0 = pressed, 1 = released)
//   click     out  one-cycle pulse, single short click completed
//   dclick    out  one-cycle pulse, double click completed
//   lpress    out  one-cycle pulse, long-press threshold reached
//   repeat_o  out  one-cycle pulse every REPEAT_CNT cycles while long-held
//                  (named repeat_o because "repeat" is a reserved word)
//   held      out  level, high while the key is considered pressed
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
  parameter int unsigned DCLICK_CNT = DCLICK_CNT_DEF,
  parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic keyflag,
  input  logic keyvalue,
  output logic click,
  output logic dclick,
  output logic lpress,
  output logic repeat_o,
  output logic held
);

  // Terminal counts; every limit must fit in CNT_W bits.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             click_q, click_d;
  logic             dclick_q, dclick_d;
  logic             lpress_q, lpress_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  logic press_ev;
  logic release_ev;

  assign press_ev   = keyflag & ~keyvalue;
  assign release_ev = keyflag &  keyvalue;

  // Next-state logic. Events are checked before timeouts so a strobe that
  // lands on the timeout cycle wins. Redundant events (press while pressed,
  // release while released) simply fall through to normal counting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    lpress_d = 1'b0;
    repeat_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (press_ev) begin
          state_d = ST_PRESS1;
        end
      end

      ST_PRESS1: begin
        if (release_ev) begin
          state_d = ST_WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d  = ST_LONG;
          cnt_d    = '0;
          lpress_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT2: begin
        if (press_ev) begin
          state_d = ST_PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          click_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PRESS2: begin
        if (release_ev) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          dclick_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d  = ST_LONG;
          cnt_d    = '0;
          lpress_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_LONG: begin
        if (release_ev) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          // Wrap within the long state; the state itself does not change.
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = state_is_held(state_d);
  end

  // State, counter and every output are registered together.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      lpress_q <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      click_q  <= click_d;
      dclick_q <= dclick_d;
      lpress_q <= lpress_d;
      repeat_q <= repeat_d;
      held_q   <= held_d;
    end
  end

  assign click    = click_q;
  assign dclick   = dclick_q;
  assign lpress   = lpress_q;
  assign repeat_o = repeat_q;
  assign held     = held_q;

endmodule : key_event_decoder

`default_nettype wire
